// File: rtl/l2_req_arbiter_pkg.sv
// Shared encodings for the L2 request arbiter: FSM states, grant ids
// and L2 transfer directions.
package l2_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IC = 2'd1,
        ARB_BUSY_DC = 2'd2
    } arb_state_t;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    localparam logic L2_READ  = 1'b0;
    localparam logic L2_WRITE = 1'b1;

endpackage

// File: rtl/l2_req_arbiter_timeout_cnt.sv
// Clearable saturating cycle counter; hit is high while the count sits at LIMIT.
module arb_timeout_cnt #(
    parameter int LIMIT = 1023,
    parameter int W     = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == W'(LIMIT));

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates the single L2 request port between the L1 icache and dcache
// controllers, with round-robin tie-break and a per-transaction timeout.
module l2_req_arbiter
    import l2_req_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 28,
    parameter int TO_LIMIT = 1023,
    parameter int TO_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              drq,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_rw,
    output logic              ic_grant,
    output logic              dc_grant,
    output logic              ic_done,
    output logic              dc_done,
    output logic              ic_err,
    output logic              dc_err,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rw,
    input  logic              l2_done,
    output logic [1:0]        dbg_state
);

    arb_state_t state;
    logic       last_grant;
    logic       to_hit;
    logic       pick_dc;
    logic       busy;

    // dcache wins when alone, or on a tie when icache had the previous grant.
    always_comb begin
        pick_dc = drq && (!irq || (last_grant == GNT_IC));
    end

    assign busy = (state != ARB_IDLE);

    arb_timeout_cnt #(
        .LIMIT (TO_LIMIT),
        .W     (TO_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!busy),
        .en    (1'b1),
        .hit   (to_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_IC;
            l2_addr    <= '0;
            l2_rw      <= L2_READ;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_dc) begin
                        state      <= ARB_BUSY_DC;
                        last_grant <= GNT_DC;
                        l2_addr    <= dc_addr;
                        l2_rw      <= dc_rw;
                    end else if (irq) begin
                        state      <= ARB_BUSY_IC;
                        last_grant <= GNT_IC;
                        l2_addr    <= ic_addr;
                        l2_rw      <= L2_READ;
                    end
                end
                ARB_BUSY_IC, ARB_BUSY_DC: begin
                    if (l2_done || to_hit) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign ic_grant  = (state == ARB_BUSY_IC);
    assign dc_grant  = (state == ARB_BUSY_DC);
    assign l2_req    = ic_grant | dc_grant;

    // Completion beats timeout when both land in the same cycle.
    assign ic_done   = ic_grant & l2_done;
    assign dc_done   = dc_grant & l2_done;
    assign ic_err    = ic_grant & to_hit & ~l2_done;
    assign dc_err    = dc_grant & to_hit & ~l2_done;

    assign dbg_state = state;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: vector tables, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_l2_req_arbiter;
    import l2_req_arbiter_pkg::*;

    localparam int AW       = 28;
    localparam int TO_LIMIT = 15;
    localparam int TO_W     = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          irq, drq, dc_rw, l2_done;
    logic [AW-1:0] ic_addr, dc_addr;
    logic          ic_grant, dc_grant, ic_done, dc_done, ic_err, dc_err;
    logic          l2_req, l2_rw;
    logic [AW-1:0] l2_addr;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    l2_req_arbiter #(
        .ADDR_W   (AW),
        .TO_LIMIT (TO_LIMIT),
        .TO_W     (TO_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .ic_addr   (ic_addr),
        .drq       (drq),
        .dc_addr   (dc_addr),
        .dc_rw     (dc_rw),
        .ic_grant  (ic_grant),
        .dc_grant  (dc_grant),
        .ic_done   (ic_done),
        .dc_done   (dc_done),
        .ic_err    (ic_err),
        .dc_err    (dc_err),
        .l2_req    (l2_req),
        .l2_addr   (l2_addr),
        .l2_rw     (l2_rw),
        .l2_done   (l2_done),
        .dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: owner 0 = none, 1 = icache, 2 = dcache.
    int            m_owner, m_cnt, m_last;
    logic [AW-1:0] m_addr;
    logic          m_rw;
    logic          e_ic_done, e_dc_done, e_ic_err, e_dc_err;

    typedef struct {
        logic          rst_before;
        logic          irq, drq, rw, done;
        logic [AW-1:0] ia, da;
        logic          e_icg, e_dcg, e_icd, e_dcd;
        logic [AW-1:0] e_addr;
        logic          e_rw;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_cnt   = 0;
        m_addr  = '0;
        m_rw    = 1'b0;
    endtask

    task automatic model_eval();
        e_ic_done = (m_owner == 1) && l2_done;
        e_dc_done = (m_owner == 2) && l2_done;
        e_ic_err  = (m_owner == 1) && !l2_done && (m_cnt == TO_LIMIT);
        e_dc_err  = (m_owner == 2) && !l2_done && (m_cnt == TO_LIMIT);
    endtask

    task automatic model_check();
        chk("ic_grant", 32'(ic_grant), 32'(m_owner == 1));
        chk("dc_grant", 32'(dc_grant), 32'(m_owner == 2));
        chk("l2_req",   32'(l2_req),   32'(m_owner != 0));
        chk("l2_addr",  32'(l2_addr),  32'(m_addr));
        chk("l2_rw",    32'(l2_rw),    32'(m_rw));
        chk("ic_done",  32'(ic_done),  32'(e_ic_done));
        chk("dc_done",  32'(dc_done),  32'(e_dc_done));
        chk("ic_err",   32'(ic_err),   32'(e_ic_err));
        chk("dc_err",   32'(dc_err),   32'(e_dc_err));
    endtask

    task automatic model_advance();
        int w;
        if (m_owner != 0) begin
            if (e_ic_done || e_dc_done || e_ic_err || e_dc_err) m_owner = 0;
            else m_cnt++;
        end else begin
            w = 0;
            if (irq && drq) w = (m_last == 1) ? 2 : 1;
            else if (drq)   w = 2;
            else if (irq)   w = 1;
            if (w != 0) begin
                m_owner = w;
                m_last  = w;
                m_cnt   = 0;
                m_addr  = (w == 2) ? dc_addr : ic_addr;
                m_rw    = (w == 2) ? dc_rw : 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic i_irq, input logic i_drq, input logic i_rw,
                         input logic i_done, input logic [AW-1:0] ia, input logic [AW-1:0] da);
        @(negedge clk);
        irq = i_irq; drq = i_drq; dc_rw = i_rw; l2_done = i_done;
        ic_addr = ia; dc_addr = da;
        #4;
        model_eval();
        model_check();
        model_advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        irq = 1'b0; drq = 1'b0; dc_rw = 1'b0; l2_done = 1'b0;
        #4;
        model_reset();
        chk("rst_l2_req",   32'(l2_req), 32'd0);
        chk("rst_grants",   32'({ic_grant, dc_grant}), 32'd0);
        chk("rst_l2_addr",  32'(l2_addr), 32'd0);
        chk("rst_state",    32'(dbg_state), 32'(ARB_IDLE));
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic rb, input logic i, input logic d, input logic rw,
                                input logic dn, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                input logic icg, input logic dcg, input logic icd, input logic dcd,
                                input logic [AW-1:0] ea, input logic erw);
        vec_t v;
        v.rst_before = rb; v.irq = i; v.drq = d; v.rw = rw; v.done = dn;
        v.ia = ia; v.da = da;
        v.e_icg = icg; v.e_dcg = dcg; v.e_icd = icd; v.e_dcd = dcd;
        v.e_addr = ea; v.e_rw = erw;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a_ic, a_dc, a_x;
        int            order[$];
        int            exp_order[6];
        logic          prev_ic, prev_dc;
        int            busy_n, err_at, regrant, saw_idle, done_seen;
        logic          ir, dr;

        a_ic = 28'h0000ABC;
        a_dc = 28'h1234567;
        a_x  = 28'h0005555;
        reset = 1'b0;
        irq = 1'b0; drq = 1'b0; dc_rw = 1'b0; l2_done = 1'b0;
        ic_addr = '0; dc_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // irq only; address change mid-transaction; idle l2_done ignored
        tbl.push_back(mk(1, 1,0,0,0, a_ic, '0,   0,0,0,0, '0,   0));
        tbl.push_back(mk(0, 1,0,0,0, a_ic, '0,   1,0,0,0, a_ic, 0));
        tbl.push_back(mk(0, 1,0,0,0, a_ic, '0,   1,0,0,0, a_ic, 0));
        tbl.push_back(mk(0, 1,0,0,0, a_x,  '0,   1,0,0,0, a_ic, 0));
        tbl.push_back(mk(0, 1,0,0,0, a_ic, '0,   1,0,0,0, a_ic, 0));
        tbl.push_back(mk(0, 1,0,0,1, a_ic, '0,   1,0,1,0, a_ic, 0));
        tbl.push_back(mk(0, 0,0,0,0, a_ic, '0,   0,0,0,0, a_ic, 0));
        // simultaneous requests after reset: dcache first, then icache
        tbl.push_back(mk(1, 1,1,1,0, a_ic, a_dc, 0,0,0,0, '0,   0));
        tbl.push_back(mk(0, 1,1,1,0, a_ic, a_dc, 0,1,0,0, a_dc, 1));
        tbl.push_back(mk(0, 1,1,1,1, a_ic, a_dc, 0,1,0,1, a_dc, 1));
        tbl.push_back(mk(0, 1,0,0,0, a_ic, a_dc, 0,0,0,0, a_dc, 1));
        tbl.push_back(mk(0, 1,0,0,1, a_ic, a_dc, 1,0,1,0, a_ic, 0));
        tbl.push_back(mk(0, 0,0,0,1, a_ic, a_dc, 0,0,0,0, a_ic, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            @(negedge clk);
            irq = tbl[i].irq; drq = tbl[i].drq; dc_rw = tbl[i].rw; l2_done = tbl[i].done;
            ic_addr = tbl[i].ia; dc_addr = tbl[i].da;
            #4;
            chk($sformatf("tbl%0d_ic_grant", i), 32'(ic_grant), 32'(tbl[i].e_icg));
            chk($sformatf("tbl%0d_dc_grant", i), 32'(dc_grant), 32'(tbl[i].e_dcg));
            chk($sformatf("tbl%0d_l2_req", i),   32'(l2_req),   32'(tbl[i].e_icg | tbl[i].e_dcg));
            chk($sformatf("tbl%0d_ic_done", i),  32'(ic_done),  32'(tbl[i].e_icd));
            chk($sformatf("tbl%0d_dc_done", i),  32'(dc_done),  32'(tbl[i].e_dcd));
            chk($sformatf("tbl%0d_errs", i),     32'({ic_err, dc_err}), 32'd0);
            chk($sformatf("tbl%0d_l2_addr", i),  32'(l2_addr),  32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_l2_rw", i),    32'(l2_rw),    32'(tbl[i].e_rw));
            model_eval();
            model_advance();
        end

        // reset asserted mid-BUSY_DC while l2_done is high
        do_reset();
        cycle(0, 1, 1, 0, a_ic, a_dc);
        cycle(0, 1, 1, 0, a_ic, a_dc);
        chk("pre_rst_dc_grant", 32'(dc_grant), 32'd1);
        @(negedge clk);
        l2_done = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("midrst_outs", 32'({ic_grant, dc_grant, l2_req, l2_rw, ic_done, dc_done, ic_err, dc_err}), 32'd0);
        chk("midrst_l2_addr", 32'(l2_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1; l2_done = 1'b0; drq = 1'b0;
        model_reset();
        cycle(0, 0, 0, 0, a_ic, a_dc);
        chk("postrst_state", 32'(dbg_state), 32'(ARB_IDLE));

        // fairness: both held, done 3 cycles after each grant
        do_reset();
        exp_order = '{2, 1, 2, 1, 2, 1};
        prev_ic = 1'b0; prev_dc = 1'b0;
        for (int c = 0; c < 100 && order.size() < 6; c++) begin
            cycle(1, 1, 1'($urandom_range(0, 1)), (m_owner != 0) && (m_cnt == 3),
                  AW'($urandom), AW'($urandom));
            if (dc_grant && !prev_dc) order.push_back(2);
            if (ic_grant && !prev_ic) order.push_back(1);
            prev_ic = ic_grant; prev_dc = dc_grant;
        end
        chk("fair_len", 32'(order.size()), 32'd6);
        for (int k = 0; k < order.size() && k < 6; k++)
            chk($sformatf("fair_order%0d", k), 32'(order[k]), 32'(exp_order[k]));

        // timeout: l2_done never arrives
        do_reset();
        busy_n = 0; err_at = -1; regrant = 0; saw_idle = 0; done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(0, 1, 0, 0, a_ic, a_dc);
            if (dc_grant && err_at < 0) busy_n++;
            if (dc_err && err_at < 0) err_at = busy_n;
            if (dc_done) done_seen = 1;
            if (err_at >= 0 && !dc_grant) saw_idle = 1;
            if (saw_idle && dc_grant) regrant = 1;
        end
        chk("to_err_cycle", 32'(err_at), 32'd16);
        chk("to_no_done",   32'(done_seen), 32'd0);
        chk("to_regrant",   32'(regrant), 32'd1);

        // l2_done coincides with the timeout: done wins
        do_reset();
        cycle(0, 1, 1, 0, a_ic, a_dc);
        repeat (TO_LIMIT) cycle(0, 1, 1, 0, a_ic, a_dc);
        cycle(0, 1, 1, 1, a_ic, a_dc);
        chk("edge_dc_done", 32'(dc_done), 32'd1);
        chk("edge_dc_err",  32'(dc_err),  32'd0);
        cycle(0, 0, 0, 0, a_ic, a_dc);
        chk("edge_idle_req", 32'(l2_req), 32'd0);

        // randomized traffic against the model
        do_reset();
        ir = 1'b0; dr = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (!ir && $urandom_range(0, 2) == 0) ir = 1'b1;
            if (!dr && $urandom_range(0, 2) == 0) dr = 1'b1;
            if (m_owner == 1 && $urandom_range(0, 15) == 0) ir = 1'b0;
            if (m_owner == 2 && $urandom_range(0, 15) == 0) dr = 1'b0;
            cycle(ir, dr, 1'($urandom_range(0, 1)),
                  (m_owner != 0) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 5) == 0),
                  AW'($urandom), AW'($urandom));
            chk("inv_onehot", 32'(ic_grant & dc_grant), 32'd0);
            if (e_ic_done || e_ic_err) ir = 1'b0;
            if (e_dc_done || e_dc_err) dr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares the single L2 cache request port between the L1 instruction cache controller and the L1 data cache controller.
- Latches the winning requester's block address and direction, then drives the L2 port until L2 signals completion.
- Returns a done or error pulse to the owner of the transaction.
- Sits between the icache/dcache controllers (IF and MEM stages) and the L2 cache controller.

Parameters:
- ADDR_W, 28, block address width (word address bits [31:4]).
- TO_LIMIT, 1023, timeout: number of cycles in a busy state before the transaction is aborted.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TO_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- irq  in  1  icache request; level, held until ic_done or ic_err
- ic_addr  in  ADDR_W  icache block address
- drq  in  1  dcache request; level, held until dc_done or dc_err
- dc_addr  in  ADDR_W  dcache block address
- dc_rw  in  1  dcache direction, 1 = write-back, 0 = refill
- ic_grant  out  1  high while the icache owns the L2 port
- dc_grant  out  1  high while the dcache owns the L2 port
- ic_done  out  1  one-cycle pulse, icache transaction complete
- dc_done  out  1  one-cycle pulse, dcache transaction complete
- ic_err  out  1  one-cycle pulse, icache transaction timed out
- dc_err  out  1  one-cycle pulse, dcache transaction timed out
- l2_req  out  1  request to L2, high for the whole transaction
- l2_addr  out  ADDR_W  latched address
- l2_rw  out  1  latched direction; always 0 for icache transactions
- l2_done  in  1  L2 completion pulse

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, last_grant = IC, timeout counter = 0.
  - All outputs 0.
  - Reset may assert at any time, including mid-transaction; the in-flight transaction is dropped with no done or err pulse.
- States: IDLE, BUSY_IC, BUSY_DC.
- IDLE:
  - Only irq → BUSY_IC.
  - Only drq → BUSY_DC.
  - Both → the requester not equal to last_grant wins. After reset, last_grant = IC, so dcache wins the first tie.
  - On the transition edge: latch l2_addr; latch l2_rw (dc_rw for dcache, 0 for icache); update last_grant; clear the counter.
  - Grant latency: request seen in IDLE at cycle N → grant and l2_req high from cycle N+1.
- BUSY_x:
  - x_grant = 1 and l2_req = 1.
  - l2_addr and l2_rw are stable and ignore input changes.
  - The counter increments every cycle and saturates at TO_LIMIT.
- l2_done = 1 in BUSY_x:
  - x_done pulses the same cycle (combinational from l2_done and state).
  - Next state is IDLE; grant and l2_req drop at the next edge.
- Timeout: counter == TO_LIMIT and l2_done = 0:
  - x_err pulses.
  - Next state is IDLE.
  - If l2_done and timeout coincide, done wins and no err is raised.
- Turnaround: at least one IDLE cycle separates consecutive transactions; l2_req is low for at least 1 cycle between them.
- Requester behaviour during a transaction:
  - If the owner drops its request mid-transaction, this is ignored; the transaction completes and done still pulses.
  - The non-owner's request is held pending and evaluated in IDLE.
- l2_done in IDLE is ignored; no pulse is generated.
- Invariants:
  - ic_grant and dc_grant are never both 1.
  - The done/err pulses are mutually exclusive.
  - l2_req == ic_grant | dc_grant.
- Fairness: with both requesters held high continuously, grants strictly alternate.

Decomposition:
- Shared header (cpu.h style), containing:
  - the state encodings ARB_IDLE / ARB_BUSY_IC / ARB_BUSY_DC (2 bits);
  - the grant-id constants GNT_IC = 0 and GNT_DC = 1;
  - the L2 direction constants L2_READ = 0 and L2_WRITE = 1.
- One natural sub-module: arb_timeout_cnt, a clearable saturating counter with a hit output.
- The FSM and latches stay in the top-level module.

Test Plan:
- Reset mid-BUSY_DC: reset low for 1 cycle → all outputs 0 immediately, no dc_done; after release, state is IDLE.
- irq only, ic_addr = 0x0000ABC, l2_done 5 cycles later:
  - ic_grant, l2_req, l2_addr = 0x0000ABC, l2_rw = 0 from N+1;
  - ic_done pulses once in the l2_done cycle; l2_req low the next cycle.
- irq and drq raised in the same cycle after reset:
  - dcache granted first (l2_rw = dc_rw = 1, dc_addr = 0x1234567);
  - after dc_done, one idle cycle, then icache granted.
- Both requests held for 6 transactions, each with l2_done 3 cycles after grant → grant order DC, IC, DC, IC, DC, IC.
- TO_LIMIT = 15, drq held, l2_done never asserted:
  - dc_err pulses exactly when the counter reaches 15 (16th busy cycle); no dc_done;
  - then IDLE, and the request is re-granted.
- Boundary and ignore cases:
  - l2_done in the same cycle the counter hits TO_LIMIT → dc_done = 1, dc_err = 0.
  - ic_addr changed during BUSY_IC → l2_addr unchanged.
